// File: rtl/decryption6b.sv
// Purpose : receive-side 6-bit LFSR stream decryptor; XORs datain[5:0] with the key after STEPS shifts.
// Latency : STEPS cycles from the accept edge to the ready pulse; one byte per STEPS+1 cycles.
// Backpressure: none queued; in_valid is ignored while busy, so the sender must wait for busy=0.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   load             synchronous reseed: key <= SEED and abort any byte in flight
//   in_valid, datain ciphertext byte, taken only while idle
//   busy             high while a byte is shifting (decoded from state)
//   ready, dataout   one-cycle completion pulse; plaintext held until the next completion
//   key              current LFSR state
module decryption6b #(
  parameter logic [5:0] SEED  = 6'b000001,
  parameter int         STEPS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       in_valid,
  input  logic [7:0] datain,
  output logic       busy,
  output logic       ready,
  output logic [7:0] dataout,
  output logic [5:0] key
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [3:0] LAST = 4'(STEPS - 1);

  state_t     state, state_nxt;
  logic [7:0] buffer;
  logic [3:0] cnt;
  logic [5:0] key_next;
  logic       done;

  // x^6 + x^5 + 1, maximal length (period 63)
  assign key_next = {key[4:0], key[5] ^ key[4]};
  assign busy     = (state == SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // load wins over a simultaneous byte, which is simply dropped
        if (!load && in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (load) begin
          state_nxt = IDLE;
        end else if (cnt == LAST) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key     <= SEED;
      buffer  <= 8'h00;
      cnt     <= 4'd0;
      dataout <= 8'h00;
      ready   <= 1'b0;
    end else begin
      // ready is set only on the completing edge and cleared on every other
      ready <= done;
      if (load) begin
        key <= SEED;
        cnt <= 4'd0;
      end else if (state == IDLE) begin
        if (in_valid) begin
          buffer <= datain;
          cnt    <= 4'd0;
        end
      end else begin
        key <= key_next;
        cnt <= cnt + 4'd1;
        if (done) begin
          // the final key of this byte is the one being loaded on this edge
          dataout <= {buffer[7:6], buffer[5:0] ^ key_next};
          cnt     <= 4'd0;
        end
      end
    end
  end

endmodule

// File: doc/decryption6b.md
# decryption6b

Receive-side counterpart of the 6-bit LFSR stream cipher. The block takes one ciphertext byte and advances a 6-bit key LFSR by STEPS positions. It then XORs the low six bits with the resulting key and returns the plaintext byte with a one-cycle `ready` pulse. Both ends load the same seed and consume one key per byte, so a stream encrypted by the transmit-side encryptor is recovered byte for byte; the upper two bits pass through unchanged.

## Interface
- SEED, 6'b000001, key value after reset or `load`; must be nonzero.
- STEPS, 6, LFSR shifts per byte; legal range 1..15.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- load  in  1  synchronous reseed strobe: key <= SEED, abort any byte in flight
- in_valid  in  1  ciphertext byte present on datain; accepted only when idle
- datain  in  8  ciphertext byte
- busy  out  1  high while a byte is being processed; in_valid ignored
- ready  out  1  one-cycle pulse, dataout holds a new plaintext byte
- dataout  out  8  plaintext byte; held until the next ready
- key  out  6  current LFSR state

## Operation
- LFSR step (x^6+x^5+1, period 63): key_next = {key[4:0], key[5]^key[4]}.
- Registers: 6-bit key, 8-bit cipher buffer, 4-bit step counter, dataout, ready, 2-state FSM (IDLE, SHIFT).
- Reset values: key=SEED, dataout=8'h00, ready=0, busy=0, counter=0, state=IDLE.
- IDLE:
  - load=1: key<=SEED, stay IDLE. load has priority; a simultaneous in_valid byte is dropped.
  - in_valid=1 and load=0: buffer<=datain, counter<=0, state<=SHIFT.
- SHIFT:
  - Each cycle: key<=key_next, counter++.
  - On the cycle where counter==STEPS-1:
    - dataout<={buffer[7:6], buffer[5:0]^key_next}
    - ready<=1
    - state<=IDLE
- ready is registered and cleared on every edge where it is not being set.
- busy = (state==SHIFT), combinational from state.
- load in SHIFT: key<=SEED, state<=IDLE, counter<=0, no ready pulse, dataout unchanged.
- in_valid while busy: ignored. There is no queue, and the sender must wait for busy=0.
- rst asserted at any time: all registers take their reset values immediately, without waiting for clk.
- Key sequence continues across bytes. Only rst or load restarts it at SEED.

## Timing
- Edge E0 accepts the byte (busy high after E0).
- Shift edges E1..E(STEPS). At E(STEPS): ready=1, dataout valid, busy=0.
- With default STEPS, latency is 6 cycles from the accept edge to ready.
- The next byte can be accepted at E(STEPS+1), which gives a throughput of one byte per STEPS+1 cycles.
- ready falls at E(STEPS+1). dataout remains stable until the next completion.
- key is visible every cycle and changes on every shift edge. It holds in IDLE.

## Test plan
- Reset, then idle: after rst, verify key=000001, ready=0, busy=0, dataout=00.
- Single byte: load, then datain=8'h43 with in_valid for one cycle. Required response:
  - busy high for 6 cycles
  - ready pulses once, 6 edges after accept
  - dataout=8'h40
  - key=000011
- Back-to-back bytes: after load, send 8'h43, then 8'h44 as soon as busy=0. Required response:
  - dataout=8'h40 with key=000011
  - then dataout=8'h41 with key=000101
- Busy rejection: hold in_valid=1 with a different datain throughout processing. Only the byte present at the accept edge is decoded; the next accept occurs at E7.
- Load abort: assert load at the third shift cycle. Required response:
  - no ready pulse
  - key=000001 next cycle
  - dataout retains its old value
  - a following 8'h43 decodes to 8'h40
  - load and in_valid in the same idle cycle: the byte is dropped.
- Async reset mid-byte: pulse rst between clock edges during SHIFT. Outputs return to reset values immediately, with no spurious ready.
